// File: rtl/i4001_rom.sv
// i4001 ROM/IO companion: serves instruction bytes on the 4-bit bus during M1/M2,
// decodes SRC/WRR/RDR for its I/O port, and takes its image from a host write port.
module i4001_rom #(
    parameter logic [3:0] CHIP_ID     = 4'h0,
    parameter logic [3:0] IO_OUT_MASK = 4'hF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sync,
    input  logic       i_cm_rom,
    input  logic [3:0] i_dbus_in,
    output logic [3:0] o_dbus_out,
    output logic       o_dbus_oe,
    input  logic [3:0] i_io_in,
    output logic [3:0] o_io_out,
    input  logic       i_prog_we,
    input  logic [7:0] i_prog_addr,
    input  logic [7:0] i_prog_data
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
        PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
    } phase_t;

    localparam logic [3:0] OPR_IO = 4'hE;
    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    logic [7:0] r_rom [0:255];
    phase_t     r_phase;
    phase_t     w_phase_nxt;
    logic       r_locked;
    logic       w_locked_nxt;
    logic [7:0] r_addr;
    logic       r_sel;
    logic [3:0] r_byte_lo;
    logic       r_opr_is_io;
    logic [3:0] r_opa;
    logic       r_io_pend;
    logic       r_src_sel;
    logic [3:0] r_dbus_out;
    logic       r_dbus_oe;
    logic [3:0] r_io_out;

    logic [7:0] w_byte;
    logic       w_chip_hit;
    logic       w_io_go;
    logic [3:0] w_rdr_val;

    assign w_byte     = r_rom[r_addr];
    assign w_chip_hit = (i_dbus_in == CHIP_ID);
    assign w_io_go    = r_io_pend && r_src_sel;
    assign w_rdr_val  = (r_io_out & IO_OUT_MASK) | (i_io_in & ~IO_OUT_MASK);

    assign o_dbus_out = r_dbus_out;
    assign o_dbus_oe  = r_dbus_oe;
    assign o_io_out   = r_io_out;

    // Host image load; the array is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_prog_we) begin
            r_rom[i_prog_addr] <= i_prog_data;
        end
    end

    // Phase tracker state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase  <= PH_X3;
            r_locked <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    // Phase tracker next state: sync always realigns to A1, whatever the current phase.
    always_comb begin
        w_phase_nxt  = PH_A1;
        w_locked_nxt = r_locked;
        if (i_sync) begin
            w_phase_nxt  = PH_A1;
            w_locked_nxt = 1'b1;
        end else begin
            w_phase_nxt  = phase_t'(r_phase + 3'd1);
        end
    end

    // Bus capture, fetch drive and I/O port datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr      <= 8'h00;
            r_sel       <= 1'b0;
            r_byte_lo   <= 4'h0;
            r_opr_is_io <= 1'b0;
            r_opa       <= 4'h0;
            r_io_pend   <= 1'b0;
            r_src_sel   <= 1'b0;
            r_dbus_out  <= 4'h0;
            r_dbus_oe   <= 1'b0;
            r_io_out    <= 4'h0;
        end else if (i_sync) begin
            r_dbus_oe <= 1'b0;
            r_io_pend <= 1'b0;
        end else if (r_locked) begin
            case (r_phase)
                PH_A1: r_addr[3:0] <= i_dbus_in;
                PH_A2: r_addr[7:4] <= i_dbus_in;
                PH_A3: begin
                    r_sel <= i_cm_rom && w_chip_hit;
                    if (i_cm_rom && w_chip_hit) begin
                        r_dbus_out <= w_byte[7:4];
                        r_byte_lo  <= w_byte[3:0];
                        r_dbus_oe  <= 1'b1;
                    end
                end
                PH_M1: begin
                    r_opr_is_io <= (i_dbus_in == OPR_IO);
                    if (r_sel) begin
                        r_dbus_out <= r_byte_lo;
                    end
                end
                PH_M2: begin
                    r_io_pend <= r_opr_is_io && i_cm_rom;
                    r_opa     <= i_dbus_in;
                    r_dbus_oe <= 1'b0;
                end
                PH_X1: begin
                    if (w_io_go && (r_opa == OPA_RDR)) begin
                        r_dbus_out <= w_rdr_val;
                        r_dbus_oe  <= 1'b1;
                    end
                end
                PH_X2: begin
                    r_dbus_oe <= 1'b0;
                    if (i_cm_rom && !r_io_pend) begin
                        r_src_sel <= w_chip_hit;
                    end else if (w_io_go && (r_opa == OPA_WRR)) begin
                        r_io_out <= i_dbus_in & IO_OUT_MASK;
                    end
                end
                PH_X3: r_io_pend <= 1'b0;
                default: r_io_pend <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_i4001_rom.sv
// Scoreboard bench for i4001_rom: two instances (full-output and mixed-direction I/O masks)
// share one stimulus stream; a negedge monitor pops expected {phase, nibble} on every drive.
module tb_i4001_rom;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cm_rom;
    logic [3:0] dbus_in;
    logic [3:0] io_in;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;

    logic [3:0] out0, out1, io0, io1;
    logic       oe0, oe1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] nib;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [7:0] tb_rom [0:255];
    logic [2:0] tb_ph;

    i4001_rom #(.CHIP_ID(4'h0), .IO_OUT_MASK(4'hF)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_cm_rom(cm_rom),
        .i_dbus_in(dbus_in), .o_dbus_out(out0), .o_dbus_oe(oe0),
        .i_io_in(io_in), .o_io_out(io0),
        .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_data(prog_data)
    );

    i4001_rom #(.CHIP_ID(4'h0), .IO_OUT_MASK(4'h3)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_sync(sync), .i_cm_rom(cm_rom),
        .i_dbus_in(dbus_in), .o_dbus_out(out1), .o_dbus_oe(oe1),
        .i_io_in(io_in), .o_io_out(io1),
        .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_data(prog_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every driven nibble must match the head of that instance's queue.
    always @(negedge clk) begin
        if (oe0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0 unexpected drive: phase %0d data %h, expected no drive", tb_ph, out0);
            end else begin
                e0 = q0.pop_front();
                check("dut0 drive phase", {5'd0, tb_ph}, {5'd0, e0.ph});
                check("dut0 drive data", {4'd0, out0}, {4'd0, e0.nib});
            end
        end
        if (oe1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1 unexpected drive: phase %0d data %h, expected no drive", tb_ph, out1);
            end else begin
                e1 = q1.pop_front();
                check("dut1 drive phase", {5'd0, tb_ph}, {5'd0, e1.ph});
                check("dut1 drive data", {4'd0, out1}, {4'd0, e1.nib});
            end
        end
    end

    task automatic step(input logic [2:0] ph, input logic [3:0] d, input logic cm, input logic s);
        tb_ph   = ph;
        dbus_in = d;
        cm_rom  = cm;
        sync    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tb_rom[a] = d;
        step(3'd0, 4'h0, 1'b0, 1'b0);
        prog_we   = 1'b0;
    endtask

    task automatic push_both(input logic [2:0] ph, input logic [3:0] n0, input logic [3:0] n1);
        q0.push_back({ph, n0});
        q1.push_back({ph, n1});
    endtask

    // One full instruction cycle as seen on the bus; M1/M2 carry the fetched byte.
    task automatic fetch(input logic [7:0] a, input logic [3:0] chip, input logic cm_a3,
                         input logic sel_exp, input logic cm_m2, input logic [3:0] x2d,
                         input logic cm_x2, input logic rdr_exp, input logic [3:0] rdr0,
                         input logic [3:0] rdr1, input logic pw, input logic [7:0] pd);
        logic [7:0] b;
        b = tb_rom[a];
        if (sel_exp) begin
            push_both(3'd3, b[7:4], b[7:4]);
            push_both(3'd4, b[3:0], b[3:0]);
        end
        if (rdr_exp) begin
            push_both(3'd6, rdr0, rdr1);
        end
        step(3'd0, a[3:0], 1'b0, 1'b0);
        step(3'd1, a[7:4], 1'b0, 1'b0);
        prog_we   = pw;
        prog_addr = a;
        prog_data = pd;
        step(3'd2, chip, cm_a3, 1'b0);
        prog_we = 1'b0;
        if (pw) tb_rom[a] = pd;
        step(3'd3, b[7:4], 1'b0, 1'b0);
        step(3'd4, b[3:0], cm_m2, 1'b0);
        step(3'd5, 4'h0, 1'b0, 1'b0);
        step(3'd6, x2d, cm_x2, 1'b0);
        step(3'd7, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0; io_in = 4'hC;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00; tb_ph = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset dbus_out0", {4'd0, out0}, 8'h00);
        check("reset dbus_oe0", {7'd0, oe0}, 8'h00);
        check("reset io_out0", {4'd0, io0}, 8'h00);
        check("reset io_out1", {4'd0, io1}, 8'h00);
        check("reset dbus_oe1", {7'd0, oe1}, 8'h00);
        rst = 1'b0;

        prog(8'h3C, 8'hD7);
        prog(8'h20, 8'h21);
        prog(8'h21, 8'hE2);
        prog(8'h22, 8'hEA);
        prog(8'h10, 8'h5B);
        step(3'd7, 4'h0, 1'b0, 1'b1);

        // selected fetch, wrong chip, cm_rom low
        fetch(8'h3C, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        fetch(8'h3C, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        fetch(8'h3C, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);

        // SRC 0 then WRR A; SRC 3 then WRR 5 must be ignored
        fetch(8'h20, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        fetch(8'h21, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        check("wrr io_out0", {4'd0, io0}, 8'h0A);
        check("wrr io_out1", {4'd0, io1}, 8'h02);
        fetch(8'h20, 4'h0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        fetch(8'h21, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        check("wrr other chip io_out0", {4'd0, io0}, 8'h0A);
        check("wrr other chip io_out1", {4'd0, io1}, 8'h02);

        // RDR: dut0 all outputs -> A; dut1 (2&3)|(C&C) -> E; then WRR F and RDR -> F on both
        fetch(8'h20, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        fetch(8'h22, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 4'hA, 4'hE, 1'b0, 8'h00);
        fetch(8'h21, 4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
        check("wrr F io_out0", {4'd0, io0}, 8'h0F);
        check("wrr F io_out1", {4'd0, io1}, 8'h03);
        fetch(8'h22, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00);

        // sync during M1 aborts the low-nibble drive
        push_both(3'd3, 4'hD, 4'hD);
        step(3'd0, 4'hC, 1'b0, 1'b0);
        step(3'd1, 4'h3, 1'b0, 1'b0);
        step(3'd2, 4'h0, 1'b1, 1'b0);
        step(3'd3, 4'hD, 1'b0, 1'b1);
        fetch(8'h3C, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);

        // async reset during M1 of a selected fetch
        step(3'd0, 4'hC, 1'b0, 1'b0);
        step(3'd1, 4'h3, 1'b0, 1'b0);
        step(3'd2, 4'h0, 1'b1, 1'b0);
        check("pre-reset oe0", {7'd0, oe0}, 8'h01);
        check("pre-reset dbus_out0", {4'd0, out0}, 8'h0D);
        rst = 1'b1;
        #1;
        check("async reset oe0", {7'd0, oe0}, 8'h00);
        check("async reset oe1", {7'd0, oe1}, 8'h00);
        check("async reset io_out0", {4'd0, io0}, 8'h00);
        check("async reset io_out1", {4'd0, io1}, 8'h00);
        step(3'd3, 4'h0, 1'b0, 1'b0);
        step(3'd4, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(3'd0, 4'h0, 1'b1, 1'b0);
        end
        step(3'd7, 4'h0, 1'b0, 1'b1);
        fetch(8'h3C, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);

        // host write on the A3 edge of the same address: old byte first, new byte next
        fetch(8'h10, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 8'h96);
        fetch(8'h10, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);

        step(3'd0, 4'h0, 1'b0, 1'b0);
        step(3'd1, 4'h0, 1'b0, 1'b0);
        check("dut0 drives outstanding", q0.size()[7:0], 8'h00);
        check("dut1 drives outstanding", q1.size()[7:0], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
